// File: rtl/multi_channel_stream_core.sv
// Streams DEPTH words from one or all BRAM channels out through a byte-wide UART,
// serialising each word LSB-first and pacing on the UART busy flag.
module multi_channel_stream_core #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2:0]               command,
    input  logic [NUM_CH*DATA_W-1:0] dout,
    output logic [NUM_CH-1:0]        en,
    output logic [NUM_CH*ADDR_W-1:0] addr,
    input  logic                     tx_ongoing,
    output logic                     tx_start,
    output logic [7:0]               byte_to_send,
    output logic                     busy,
    output logic                     done
);

    localparam int BYTES = DATA_W / 8;

    localparam logic [2:0]      CMD_READ_ALL = 3'd6;
    localparam logic [2:0]      CMD_ABORT    = 3'd7;
    localparam logic [2:0]      NUM_CH_C     = 3'(NUM_CH);
    localparam logic [2:0]      LAST_CH      = 3'(NUM_CH - 1);
    localparam logic [2:0]      LAST_BYTE    = 3'(BYTES - 1);
    localparam logic [1:0]      LAST_LAT     = 2'(RD_LAT - 1);
    localparam logic [ADDR_W:0] LAST_IDX     = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_RD,
        S_SEND,
        S_WAIT_ACK,
        S_WAIT_TX
    } state_t;

    state_t                   state_q, state_d;
    logic [2:0]               command_r_q;
    logic [2:0]               ch_q, ch_d;
    logic [ADDR_W-1:0]        idx_q, idx_d;
    logic [2:0]               byte_cnt_q, byte_cnt_d;
    logic [1:0]               lat_cnt_q, lat_cnt_d;
    logic [DATA_W-1:0]        word_q, word_d;
    logic                     all_q, all_d;
    logic                     abort_q, abort_d;
    logic [NUM_CH-1:0]        en_q, en_d;
    logic [NUM_CH*ADDR_W-1:0] addr_q, addr_d;
    logic                     tx_start_q, tx_start_d;
    logic [7:0]               byte_q, byte_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic [DATA_W-1:0]        rd_word;
    logic [7:0]               cur_byte;
    logic                     abort_req;
    logic                     abort_any;

    always_comb begin
        rd_word = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (ch_q == 3'(c)) begin
                rd_word = dout[c*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        cur_byte = '0;
        for (int unsigned b = 0; b < BYTES; b++) begin
            if (byte_cnt_q == 3'(b)) begin
                cur_byte = word_q[b*8 +: 8];
            end
        end
    end

    assign abort_req = (command_r_q == CMD_ABORT);
    assign abort_any = abort_q | abort_req;

    always_comb begin
        state_d    = state_q;
        ch_d       = ch_q;
        idx_d      = idx_q;
        byte_cnt_d = byte_cnt_q;
        lat_cnt_d  = lat_cnt_q;
        word_d     = word_q;
        all_d      = all_q;
        abort_d    = abort_q;
        en_d       = '0;
        addr_d     = addr_q;
        tx_start_d = 1'b0;
        byte_d     = byte_q;
        done_d     = 1'b0;

        if (state_q != S_IDLE && abort_req) begin
            abort_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                abort_d = 1'b0;
                // 6 is always READ_ALL, even when NUM_CH=6 would also map it to a channel.
                if (command_r_q == CMD_READ_ALL) begin
                    all_d   = 1'b1;
                    ch_d    = '0;
                    idx_d   = '0;
                    state_d = S_FETCH;
                end else if (command_r_q != '0 && command_r_q <= NUM_CH_C) begin
                    all_d   = 1'b0;
                    ch_d    = command_r_q - 3'd1;
                    idx_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (abort_any) begin
                    state_d = S_IDLE;
                end else begin
                    lat_cnt_d = '0;
                    state_d   = S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                if (abort_any) begin
                    state_d = S_IDLE;
                end else if (lat_cnt_q == LAST_LAT) begin
                    word_d     = rd_word;
                    byte_cnt_d = '0;
                    state_d    = S_SEND;
                end else begin
                    lat_cnt_d = lat_cnt_q + 2'd1;
                end
            end
            S_SEND: begin
                if (!tx_ongoing) begin
                    tx_start_d = 1'b1;
                    byte_d     = cur_byte;
                    state_d    = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (tx_ongoing) begin
                    state_d = S_WAIT_TX;
                end
            end
            S_WAIT_TX: begin
                // The final byte of the transfer completes normally even if abort is pending.
                if (!tx_ongoing) begin
                    if (byte_cnt_q != LAST_BYTE) begin
                        if (abort_any) begin
                            state_d = S_IDLE;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 3'd1;
                            state_d    = S_SEND;
                        end
                    end else if ({1'b0, idx_q} != LAST_IDX) begin
                        if (abort_any) begin
                            state_d = S_IDLE;
                        end else begin
                            idx_d   = idx_q + ADDR_W'(1);
                            state_d = S_FETCH;
                        end
                    end else if (all_q && ch_q != LAST_CH) begin
                        if (abort_any) begin
                            state_d = S_IDLE;
                        end else begin
                            ch_d    = ch_q + 3'd1;
                            idx_d   = '0;
                            state_d = S_FETCH;
                        end
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // FETCH is always a single-cycle state, so entering it is the one read strobe.
        if (state_d == S_FETCH) begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (ch_d == 3'(c)) begin
                    en_d[c]                   = 1'b1;
                    addr_d[c*ADDR_W +: ADDR_W] = idx_d;
                end
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            command_r_q <= '0;
            ch_q        <= '0;
            idx_q       <= '0;
            byte_cnt_q  <= '0;
            lat_cnt_q   <= '0;
            word_q      <= '0;
            all_q       <= 1'b0;
            abort_q     <= 1'b0;
            en_q        <= '0;
            addr_q      <= '0;
            tx_start_q  <= 1'b0;
            byte_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            command_r_q <= command;
            ch_q        <= ch_d;
            idx_q       <= idx_d;
            byte_cnt_q  <= byte_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            word_q      <= word_d;
            all_q       <= all_d;
            abort_q     <= abort_d;
            en_q        <= en_d;
            addr_q      <= addr_d;
            tx_start_q  <= tx_start_d;
            byte_q      <= byte_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign en           = en_q;
    assign addr         = addr_q;
    assign tx_start     = tx_start_q;
    assign byte_to_send = byte_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_multi_channel_stream_core.sv
// Directed bench: two core configurations (8-bit/RD_LAT=1 and 16-bit/RD_LAT=2) with
// behavioural BRAM and UART models.
module tb_multi_channel_stream_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0_n, rst1_n;
    logic [2:0] cmd0, cmd1;

    logic [15:0] dout0;
    logic [1:0]  en0;
    logic [19:0] addr0;
    logic        txo0, st0, busy0, done0;
    logic [7:0]  byte0;

    logic [31:0] dout1;
    logic [1:0]  en1;
    logic [1:0]  addr1;
    logic        txo1, st1, busy1, done1;
    logic [7:0]  byte1;

    multi_channel_stream_core #(.NUM_CH(2), .DATA_W(8), .ADDR_W(10), .DEPTH(4), .RD_LAT(1)) u_dut0 (
        .clk(clk), .rst_n(rst0_n), .command(cmd0), .dout(dout0), .en(en0), .addr(addr0),
        .tx_ongoing(txo0), .tx_start(st0), .byte_to_send(byte0), .busy(busy0), .done(done0)
    );

    multi_channel_stream_core #(.NUM_CH(2), .DATA_W(16), .ADDR_W(1), .DEPTH(2), .RD_LAT(2)) u_dut1 (
        .clk(clk), .rst_n(rst1_n), .command(cmd1), .dout(dout1), .en(en1), .addr(addr1),
        .tx_ongoing(txo1), .tx_start(st1), .byte_to_send(byte1), .busy(busy1), .done(done1)
    );

    // BRAM models
    logic [7:0]  mem0 [2][4];
    logic [15:0] mem1 [2][2];
    logic [15:0] stg1 [2];

    initial begin
        dout0 = '0;
        dout1 = '0;
        stg1[0] = '0;
        stg1[1] = '0;
    end

    always @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (en0[c]) dout0[c*8 +: 8] <= mem0[c][addr0[c*10 +: 2]];
            if (en1[c]) stg1[c] <= mem1[c][addr1[c]];
            dout1[c*16 +: 16] <= stg1[c];
        end
    end

    // UART models: busy rises 2 cycles after tx_start, stays 10 cycles; hold forces busy
    int  u0_dly = 0, u0_run = 0, u1_dly = 0, u1_run = 0;
    logic hold0, hold1;
    assign txo0 = hold0 || (u0_run > 0);
    assign txo1 = hold1 || (u1_run > 0);

    always @(posedge clk) begin
        if (st0 && u0_dly == 0 && u0_run == 0) u0_dly <= 2;
        else if (u0_dly > 0) begin
            if (u0_dly == 1) u0_run <= 10;
            u0_dly <= u0_dly - 1;
        end else if (u0_run > 0) u0_run <= u0_run - 1;
    end

    always @(posedge clk) begin
        if (st1 && u1_dly == 0 && u1_run == 0) u1_dly <= 2;
        else if (u1_dly > 0) begin
            if (u1_dly == 1) u1_run <= 10;
            u1_dly <= u1_dly - 1;
        end else if (u1_run > 0) u1_run <= u1_run - 1;
    end

    // Monitors
    logic [7:0] byts0[$], byts1[$];
    int adrs0[$], adrs1[$];
    int enA0 = 0, enB0 = 0, enA1 = 0, enB1 = 0;
    int done0_n = 0, done1_n = 0, viol0 = 0, viol1 = 0;
    logic pst0 = 1'b0, pst1 = 1'b0;

    always @(negedge clk) begin
        if (st0) begin
            byts0.push_back(byte0);
            if (txo0 || pst0) viol0++;
        end
        pst0 = st0;
        if (en0[0]) begin enA0++; adrs0.push_back(int'(addr0[9:0])); end
        if (en0[1]) begin enB0++; adrs0.push_back(256 + int'(addr0[19:10])); end
        if (en0 == 2'b11) viol0++;
        if (done0) begin done0_n++; if (busy0) viol0++; end
    end

    always @(negedge clk) begin
        if (st1) begin
            byts1.push_back(byte1);
            if (txo1 || pst1) viol1++;
        end
        pst1 = st1;
        if (en1[0]) begin enA1++; adrs1.push_back(int'(addr1[0])); end
        if (en1[1]) begin enB1++; adrs1.push_back(256 + int'(addr1[1])); end
        if (en1 == 2'b11) viol1++;
        if (done1) begin done1_n++; if (busy1) viol1++; end
    end

    int n_chk = 0, n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    logic [7:0] exp_b[$];
    int exp_a[$];

    task automatic check_bytes(input string tag, input int inst, input int base);
        int n;
        n = (inst == 0) ? byts0.size() : byts1.size();
        check({tag, "_nbytes"}, 32'(n - base), 32'(exp_b.size()));
        for (int i = 0; i < exp_b.size(); i++)
            if (base + i < n)
                check($sformatf("%s_byte%0d", tag, i),
                      32'((inst == 0) ? byts0[base+i] : byts1[base+i]), 32'(exp_b[i]));
    endtask

    task automatic check_addrs(input string tag, input int inst, input int base);
        int n;
        n = (inst == 0) ? adrs0.size() : adrs1.size();
        check({tag, "_nreads"}, 32'(n - base), 32'(exp_a.size()));
        for (int i = 0; i < exp_a.size(); i++)
            if (base + i < n)
                check($sformatf("%s_addr%0d", tag, i),
                      32'((inst == 0) ? adrs0[base+i] : adrs1[base+i]), 32'(exp_a[i]));
    endtask

    task automatic wait_idle(input int inst);
        int n;
        n = 0;
        while (((inst == 0) ? busy0 : busy1) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        #1;
        check("busy_drop", 32'((inst == 0) ? busy0 : busy1), 32'd0);
    endtask

    task automatic run_cmd(input int inst, input logic [2:0] c);
        @(negedge clk);
        if (inst == 0) cmd0 = c; else cmd1 = c;
        @(negedge clk);
        cmd0 = '0;
        cmd1 = '0;
        @(negedge clk);
        wait_idle(inst);
    endtask

    int b, a, d, e, n;

    initial begin
        rst0_n = 1'b0; rst1_n = 1'b0; cmd0 = '0; cmd1 = '0; hold0 = 1'b0; hold1 = 1'b0;
        mem0[0][0] = 8'h11; mem0[0][1] = 8'h22; mem0[0][2] = 8'h33; mem0[0][3] = 8'h44;
        mem0[1][0] = 8'h55; mem0[1][1] = 8'h66; mem0[1][2] = 8'h77; mem0[1][3] = 8'h88;
        mem1[0][0] = 16'h0201; mem1[0][1] = 16'h0403;
        mem1[1][0] = 16'hBEEF; mem1[1][1] = 16'h1234;

        repeat (3) @(negedge clk);
        check("rst_en", 32'(en0), 32'd0);
        check("rst_addr", 32'(addr0), 32'd0);
        check("rst_tx_start", 32'(st0), 32'd0);
        check("rst_byte", 32'(byte0), 32'd0);
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_done", 32'(done0), 32'd0);
        rst0_n = 1'b1; rst1_n = 1'b1;

        // Unused code 3 and ABORT in IDLE are ignored
        @(negedge clk) cmd0 = 3'd3;
        @(negedge clk) cmd0 = 3'd7;
        @(negedge clk) cmd0 = 3'd0;
        repeat (4) @(negedge clk);
        check("nop_busy", 32'(busy0), 32'd0);
        check("nop_reads", 32'(enA0 + enB0), 32'd0);

        // Single-channel read with command latency
        b = byts0.size(); a = adrs0.size(); d = done0_n; e = enB0;
        @(negedge clk) cmd0 = 3'd1;
        @(negedge clk) cmd0 = 3'd0;
        check("lat_busy_e0", 32'(busy0), 32'd0);
        check("lat_en_e0", 32'(en0), 32'd0);
        @(negedge clk);
        check("lat_busy_e1", 32'(busy0), 32'd1);
        check("lat_en_e1", 32'(en0), 32'd1);
        wait_idle(0);
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        check_bytes("rd_ch0", 0, b);
        exp_a = '{0, 1, 2, 3};
        check_addrs("rd_ch0", 0, a);
        check("rd_ch0_done", 32'(done0_n - d), 32'd1);
        check("rd_ch0_enB", 32'(enB0 - e), 32'd0);

        // Abort during the second byte
        b = byts0.size(); d = done0_n;
        @(negedge clk) cmd0 = 3'd1;
        @(negedge clk) cmd0 = 3'd0;
        n = 0;
        while (byts0.size() < b + 2 && n < 2000) begin @(negedge clk); n++; end
        check("abort_second_start", 32'(byts0.size() - b), 32'd2);
        cmd0 = 3'd7;
        @(negedge clk) cmd0 = 3'd0;
        wait_idle(0);
        repeat (20) @(negedge clk);
        exp_b = '{8'h11, 8'h22};
        check_bytes("abort", 0, b);
        check("abort_done", 32'(done0_n - d), 32'd0);
        check("abort_busy", 32'(busy0), 32'd0);

        b = byts0.size(); a = adrs0.size(); d = done0_n;
        run_cmd(0, 3'd1);
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        check_bytes("restart", 0, b);
        exp_a = '{0, 1, 2, 3};
        check_addrs("restart", 0, a);
        check("restart_done", 32'(done0_n - d), 32'd1);

        // Reset mid-byte
        b = byts0.size();
        @(negedge clk) cmd0 = 3'd1;
        @(negedge clk) cmd0 = 3'd0;
        n = 0;
        while (byts0.size() < b + 1 && n < 2000) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        #2 rst0_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy0), 32'd0);
        check("mid_rst_byte", 32'(byte0), 32'd0);
        check("mid_rst_tx_start", 32'(st0), 32'd0);
        check("mid_rst_en", 32'(en0), 32'd0);
        check("mid_rst_addr", 32'(addr0), 32'd0);
        check("mid_rst_done", 32'(done0), 32'd0);
        @(negedge clk) rst0_n = 1'b1;
        n = 0;
        while (txo0 && n < 100) begin @(negedge clk); n++; end
        b = byts0.size(); d = done0_n;
        run_cmd(0, 3'd1);
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        check_bytes("post_rst", 0, b);
        check("post_rst_done", 32'(done0_n - d), 32'd1);

        // 16-bit words, RD_LAT=2, tx_start withheld while UART busy
        hold1 = 1'b1;
        b = byts1.size(); a = adrs1.size(); d = done1_n; e = enA1;
        @(negedge clk) cmd1 = 3'd2;
        @(negedge clk) cmd1 = 3'd0;
        repeat (20) @(negedge clk);
        check("hold_no_start", 32'(byts1.size() - b), 32'd0);
        check("hold_busy", 32'(busy1), 32'd1);
        hold1 = 1'b0;
        wait_idle(1);
        exp_b = '{8'hEF, 8'hBE, 8'h34, 8'h12};
        check_bytes("w16_ch1", 1, b);
        exp_a = '{256, 257};
        check_addrs("w16_ch1", 1, a);
        check("w16_ch1_done", 32'(done1_n - d), 32'd1);
        check("w16_ch1_enA", 32'(enA1 - e), 32'd0);

        // READ_ALL
        b = byts1.size(); a = adrs1.size(); d = done1_n;
        run_cmd(1, 3'd6);
        exp_b = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hEF, 8'hBE, 8'h34, 8'h12};
        check_bytes("all", 1, b);
        exp_a = '{0, 1, 256, 257};
        check_addrs("all", 1, a);
        check("all_done", 32'(done1_n - d), 32'd1);

        check("protocol_dut0", 32'(viol0), 32'd0);
        check("protocol_dut1", 32'(viol1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/multi_channel_stream_core.md
# multi_channel_stream_core

Parametrised coprocessor core that streams the contents of NUM_CH block-RAM channels out through the byte-wide UART transmitter. It decodes a command, reads DEPTH words from one channel or from all channels in sequence, serialises each DATA_W-bit word into bytes LSB-first, and paces transfers on the UART busy flag. Compared with the current two-channel, byte-only core, it adds a single-pass all-channel mode, an abort command, a completion pulse and a configurable BRAM read latency. It sits between the UART receive command decoder, the channel BRAM B-ports and the UART transmitter.

## Interface
- NUM_CH, 2, number of BRAM channels (1..6)
- DATA_W, 8, BRAM word width; multiple of 8, max 32
- ADDR_W, 10, BRAM address width
- DEPTH, 1024, words per channel; 1 ≤ DEPTH ≤ 2^ADDR_W
- RD_LAT, 1, BRAM read latency in cycles (1 or 2)
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous assert, active-low
- command  in  3  command code, sampled every cycle
- dout  in  NUM_CH*DATA_W  read data; channel c in bits [c*DATA_W +: DATA_W]
- en  out  NUM_CH  per-channel read enable
- addr  out  NUM_CH*ADDR_W  per-channel address; channel c in [c*ADDR_W +: ADDR_W]
- tx_ongoing  in  1  UART busy
- tx_start  out  1  one-cycle start pulse to UART
- byte_to_send  out  8  byte for UART
- busy  out  1  high from leaving IDLE until return to IDLE
- done  out  1  one-cycle pulse on normal completion

## Operation
- Commands: 0 = NOP; 1..NUM_CH = READ channel (command−1); 6 = READ_ALL (channels 0..NUM_CH−1 in order); 7 = ABORT. Codes NUM_CH+1..5 are treated as NOP.
- command is registered once (command_r) before decode.
- In IDLE, only READ and READ_ALL are accepted. While busy, only ABORT is acted on; all other codes are ignored.
- States:
  - IDLE
  - FETCH: en[ch]=1 for one cycle with addr[ch]=idx
  - WAIT_RD: waits RD_LAT cycles, then captures dout[ch] into word_r and sets byte_cnt=0
  - SEND: when tx_ongoing=0, pulses tx_start with byte_to_send = word_r[byte_cnt*8 +: 8]
  - WAIT_ACK: waits for tx_ongoing=1
  - WAIT_TX: waits for tx_ongoing=0
- Sequencing after WAIT_TX:
  - if byte_cnt < DATA_W/8−1: byte_cnt++, go to SEND
  - else if idx < DEPTH−1: idx++, go to FETCH
  - else if READ_ALL and ch < NUM_CH−1: ch++, idx=0, go to FETCH
  - else: done pulse, go to IDLE
- idx never wraps. Last-address detection is compare-equal to DEPTH−1, sized ADDR_W+1 internally so that DEPTH = 2^ADDR_W is legal.
- ABORT while busy: latched as a flag. It takes effect at the next byte boundary (exit from WAIT_TX), or immediately if the block is in FETCH or WAIT_RD. The block then returns to IDLE with no done pulse. A byte already started is never truncated.
- en is zero for all non-selected channels at all times; addr holds its last value when en=0.

## Timing
- Reset values: en=0, addr=0, tx_start=0, byte_to_send=0, busy=0, done=0; state=IDLE, command_r=0. Reset mid-transfer aborts immediately; tx_start is low from reset assertion onward.
- All outputs are registered.
- Command latency:
  - command is sampled at edge E0; command_r is valid after E0
  - at E1 the state moves to FETCH; busy=1 and en=1 are both visible after E1
  - data is captured RD_LAT cycles after en
- tx_start is high for exactly one cycle and never asserted while tx_ongoing=1.
- byte_to_send is stable from the tx_start cycle until the next tx_start.
- The UART raises tx_ongoing within 1..4 cycles of tx_start. The block waits indefinitely.
- done and the busy falling edge occur on the same cycle.
- ABORT and the final byte completing in the same cycle: completion wins, and done pulses.

## Test plan
- NUM_CH=2, DATA_W=8, DEPTH=4; A=11,22,33,44; command=1 for 1 cycle; UART model busy 10 cycles/byte → bytes 11,22,33,44 in order, en_A only, addr 0..3, one done pulse, en_B never high.
- DATA_W=16, DEPTH=2, ch1 = 0xBEEF,0x1234; command=2 → bytes EF,BE,34,12; exactly one en per word.
- READ_ALL with DEPTH=2, A=01,02, B=03,04 → 01,02,03,04; addr for B restarts at 0; single done at end.
- ABORT issued while the second byte is being transmitted → that byte completes, no third tx_start, busy falls, no done; a subsequent command=1 restarts at addr 0.
- RD_LAT=2 → captured byte equals BRAM content at the enabled addr (not the previous address); tx_ongoing held high before start → tx_start is withheld until it drops.
- rst_n pulled low mid-byte → all outputs 0 asynchronously; after release, IDLE and a new command is accepted normally.
